// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential, branch, jump and trap sources,
// with stall/backpressure handling and a one-entry pending-redirect buffer.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            pc_valid_o,
    output logic            redirect_pending_o,
    output logic            misaligned_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_trap_q, pend_trap_d;

    logic            req;
    logic [XLEN-1:0] req_tgt;
    logic            may_overwrite;
    logic [XLEN-1:0] pc_plus;

    function automatic logic [XLEN-1:0] select_target(
        input logic            trap,
        input logic [XLEN-1:0] trap_vec,
        input logic            jump,
        input logic [XLEN-1:0] jump_tgt,
        input logic [XLEN-1:0] branch_tgt
    );
        if (trap)
            return trap_vec;
        else if (jump)
            return jump_tgt;
        else
            return branch_tgt;
    endfunction

    assign req     = trap_i | jump_i | branch_taken_i;
    assign req_tgt = select_target(trap_i, trap_vector_i, jump_i, jump_target_i, branch_target_i);
    assign pc_plus = pc_q + XLEN'(INSTR_BYTES);

    // A buffered trap target survives everything except a newer trap.
    assign may_overwrite = (state_q != PEND) || !pend_trap_q || trap_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_tgt_d  = pend_tgt_q;
        pend_trap_d = pend_trap_q;

        if (state_q == BOOT) begin
            if (req) begin
                pend_tgt_d  = req_tgt;
                pend_trap_d = trap_i;
                state_d     = PEND;
            end else begin
                state_d = RUN;
            end
        end else if (stall_i) begin
            if (req) begin
                if (may_overwrite) begin
                    pend_tgt_d  = req_tgt;
                    pend_trap_d = trap_i;
                end
                state_d = PEND;
            end
        end else if (req) begin
            // The in-flight fetch is abandoned, so fetch_ready_i is ignored here.
            pc_d        = req_tgt;
            pend_tgt_d  = '0;
            pend_trap_d = 1'b0;
            state_d     = RUN;
        end else if (state_q == PEND) begin
            pc_d        = pend_tgt_q;
            pend_tgt_d  = '0;
            pend_trap_d = 1'b0;
            state_d     = RUN;
        end else if (fetch_ready_i) begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            pend_tgt_q  <= '0;
            pend_trap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_trap_q <= pend_trap_d;
        end
    end

    assign pc_o               = pc_q;
    assign pc_plus_o          = pc_plus;
    assign pc_valid_o         = (state_q != BOOT);
    assign redirect_pending_o = (state_q == PEND);
    assign misaligned_o       = (pc_q & XLEN'(INSTR_BYTES - 1)) != '0;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized bench for pc_gen against a queue-based reference model.
module tb_pc_gen;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam int          IB   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, fetch_ready_i;
    logic        branch_taken_i, jump_i, trap_i;
    logic [31:0] branch_target_i, jump_target_i, trap_vector_i;
    logic [31:0] pc_o, pc_plus_o;
    logic        pc_valid_o, redirect_pending_o, misaligned_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] t;
        bit          trap;
    } redir_t;

    redir_t      pend_q[$];
    logic [31:0] m_pc;
    bit          m_boot;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .INSTR_BYTES(IB)) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .fetch_ready_i      (fetch_ready_i),
        .branch_taken_i     (branch_taken_i),
        .branch_target_i    (branch_target_i),
        .jump_i             (jump_i),
        .jump_target_i      (jump_target_i),
        .trap_i             (trap_i),
        .trap_vector_i      (trap_vector_i),
        .pc_o               (pc_o),
        .pc_plus_o          (pc_plus_o),
        .pc_valid_o         (pc_valid_o),
        .redirect_pending_o (redirect_pending_o),
        .misaligned_o       (misaligned_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RV;
        m_boot = 1'b1;
        pend_q.delete();
    endtask

    task automatic buffer_redirect(input logic [31:0] tgt, input bit is_trap);
        redir_t r;
        r.t    = tgt;
        r.trap = is_trap;
        if (pend_q.size() == 0)
            pend_q.push_back(r);
        else if (!pend_q[0].trap || is_trap)
            pend_q[0] = r;
    endtask

    // Applies the clock-edge behaviour to the model using the inputs just sampled.
    task automatic model_update();
        bit          req;
        logic [31:0] tgt;
        req = trap_i | jump_i | branch_taken_i;
        tgt = trap_i ? trap_vector_i : (jump_i ? jump_target_i : branch_target_i);
        if (m_boot) begin
            if (req) buffer_redirect(tgt, trap_i);
            m_boot = 1'b0;
        end else if (stall_i) begin
            if (req) buffer_redirect(tgt, trap_i);
        end else if (req) begin
            m_pc = tgt;
            pend_q.delete();
        end else if (pend_q.size() != 0) begin
            m_pc = pend_q[0].t;
            pend_q.delete();
        end else if (fetch_ready_i) begin
            m_pc = m_pc + 32'(IB);
        end
    endtask

    task automatic chk_model();
        chk("pc_o", pc_o, m_pc);
        chk("pc_plus_o", pc_plus_o, m_pc + 32'(IB));
        chk("pc_valid_o", {31'b0, pc_valid_o}, {31'b0, !m_boot});
        chk("redirect_pending_o", {31'b0, redirect_pending_o}, {31'b0, pend_q.size() != 0});
        chk("misaligned_o", {31'b0, misaligned_o}, {31'b0, (m_pc % IB) != 0});
    endtask

    task automatic drive(input bit s, input bit fr,
                         input bit br, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt,
                         input bit t, input logic [31:0] tv);
        stall_i         = s;
        fetch_ready_i   = fr;
        branch_taken_i  = br;
        branch_target_i = bt;
        jump_i          = j;
        jump_target_i   = jt;
        trap_i          = t;
        trap_vector_i   = tv;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk_model();
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model();
        reset = 1'b0;
        #1;
        chk_model();

        // Boot then sequential fetch
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        chk("seq_pc", pc_o, 32'h0000_000C);

        // Priority: trap > jump > branch
        drive(0, 1, 0, 0, 1, 32'h10, 0, 0);
        step();
        drive(0, 1, 1, 32'h300, 1, 32'h200, 1, 32'h80);
        step();
        chk("prio_trap", pc_o, 32'h80);
        drive(0, 1, 0, 0, 1, 32'h10, 0, 0);
        step();
        drive(0, 1, 1, 32'h300, 1, 32'h200, 0, 0);
        step();
        chk("prio_jump", pc_o, 32'h200);

        // Newer redirect overwrites a buffered branch during stall
        drive(0, 1, 0, 0, 1, 32'h40, 0, 0);
        step();
        drive(1, 1, 1, 32'h100, 0, 0, 0, 0);
        step();
        chk("stall_hold", pc_o, 32'h40);
        chk("stall_pend", {31'b0, redirect_pending_o}, 32'h1);
        drive(1, 1, 0, 0, 1, 32'h180, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("pend_release", pc_o, 32'h180);
        chk("pend_cleared", {31'b0, redirect_pending_o}, 32'h0);

        // Buffered trap is not displaced by a later branch
        drive(1, 1, 0, 0, 0, 0, 1, 32'h80);
        step();
        drive(1, 1, 1, 32'h100, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("trap_sticky", pc_o, 32'h80);

        // Backpressure hold, then misaligned branch target
        drive(0, 1, 0, 0, 1, 32'h20, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();
        chk("bp_hold", pc_o, 32'h20);
        drive(0, 0, 1, 32'h22, 0, 0, 0, 0);
        step();
        chk("misaligned_pc", pc_o, 32'h22);
        chk("misaligned_flag", {31'b0, misaligned_o}, 32'h1);

        // Wrap-around increment
        drive(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step();
        chk("plus_wrap", pc_plus_o, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("pc_wrap", pc_o, 32'h0);

        // Asynchronous reset while a redirect is pending
        drive(1, 1, 1, 32'h500, 0, 0, 0, 0);
        step();
        chk("pre_reset_pend", {31'b0, redirect_pending_o}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_model();
        chk("async_rst_pc", pc_o, RV);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_model();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 127) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                chk_model();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 5) == 0, rand_tgt(),
                  $urandom_range(0, 7) == 0, rand_tgt(),
                  $urandom_range(0, 11) == 0, rand_tgt());
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
